// File: rtl/hpu_sequencer.sv
// rtl/hpu_sequencer.sv - front-end sequencer feeding random words and instruction bundles to the core array
module hpu_sequencer #(
    parameter int THREADS = 5,
    parameter int WI      = 31,
    parameter int LAST_TO = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  gen_en,
    input  logic [9:0]            item_count,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [31:0]           s_data,
    input  logic                  s_last,
    input  logic                  out_ready,
    input  logic                  core_last,
    output logic                  run,
    output logic                  com,
    output logic                  get_c,
    output logic [31:0]           get_d_all,
    output logic                  get_v,
    output logic [16*THREADS-1:0] get_d,
    output logic                  exec,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // Counter widths; the shared cycle counter must reach both the drain length and the timeout.
    localparam int WW   = (WI > 0) ? $clog2(WI + 1) : 1;
    localparam int SW   = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam int CWT  = $clog2(LAST_TO + 1);
    localparam int CW   = (CWT > 2) ? CWT : 2;

    localparam logic [WW-1:0] WORD_LAST  = WW'(WI);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(THREADS - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(LAST_TO - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2);
    localparam logic [9:0]    ITEM_MAX   = 10'd512;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GEN       = 3'd1,
        S_GEN_DRAIN = 3'd2,
        S_FETCH     = 3'd3,
        S_ISSUE     = 3'd4,
        S_WAIT_LAST = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t state;
    state_t state_next;

    logic [WW-1:0]           word_cnt;
    logic [9:0]              item_cnt;
    logic [9:0]              item_total;
    logic [SW-1:0]           slot_cnt;
    logic [CW-1:0]           cnt;
    logic                    last_seen;
    logic [15:0]             slots [THREADS];
    logic [16*THREADS-1:0]   bundle;

    logic accept;
    logic start_ok;
    logic gen_accept;
    logic fetch_accept;
    logic issue_fire;
    logic timeout;
    logic item_bad;

    // The input stream is only open while collecting random words or instructions.
    assign s_ready = (state == S_GEN) || (state == S_FETCH);
    assign busy    = (state != S_IDLE);
    assign accept  = s_valid & s_ready;

    // Flatten the slot registers so slot k lands on bits [16k+15:16k].
    always_comb begin
        bundle = '0;
        for (int k = 0; k < THREADS; k++) begin
            bundle[16*k +: 16] = slots[k];
        end
    end

    // Next-state decode plus the one-cycle strobes the datapath acts on.
    always_comb begin
        state_next   = state;
        start_ok     = 1'b0;
        gen_accept   = 1'b0;
        fetch_accept = 1'b0;
        issue_fire   = 1'b0;
        timeout      = 1'b0;
        item_bad     = (item_count > ITEM_MAX);
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    if (!gen_en) begin
                        state_next = S_FETCH;
                    end else if (item_bad) begin
                        state_next = S_DONE;
                    end else if (item_count == 10'd0) begin
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_GEN;
                    end
                end
            end
            S_GEN: begin
                gen_accept = accept;
                if (accept && (word_cnt == WORD_LAST) &&
                    (item_cnt == item_total - 10'd1)) begin
                    state_next = S_GEN_DRAIN;
                end
            end
            S_GEN_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                fetch_accept = accept;
                if (accept && ((slot_cnt == SLOT_LAST) || s_last)) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (out_ready) begin
                    issue_fire = 1'b1;
                    state_next = last_seen ? S_WAIT_LAST : S_FETCH;
                end
            end
            S_WAIT_LAST: begin
                if (core_last) begin
                    state_next = S_DONE;
                end else if (cnt == TO_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered core-facing outputs, counters and the instruction slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            run        <= 1'b0;
            com        <= 1'b0;
            get_c      <= 1'b0;
            get_d_all  <= '0;
            get_v      <= 1'b0;
            get_d      <= '0;
            exec       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_cnt   <= '0;
            item_cnt   <= '0;
            item_total <= '0;
            slot_cnt   <= '0;
            cnt        <= '0;
            last_seen  <= 1'b0;
            for (int k = 0; k < THREADS; k++) begin
                slots[k] <= '0;
            end
        end else begin
            // Run spans start-accept through the DONE cycle; com spans the load plus its drain.
            run   <= (state_next != S_IDLE);
            com   <= (state_next == S_GEN) || (state_next == S_GEN_DRAIN);
            done  <= (state_next == S_DONE);
            get_c <= gen_accept;
            get_v <= issue_fire;
            get_d <= issue_fire ? bundle : '0;
            exec  <= get_v;

            if (gen_accept) begin
                get_d_all <= s_data;
            end

            if (start_ok) begin
                err <= gen_en & item_bad;
            end else if (timeout) begin
                err <= 1'b1;
            end

            if (start_ok) begin
                word_cnt   <= '0;
                item_cnt   <= '0;
                item_total <= item_count;
            end else if (gen_accept) begin
                if (word_cnt == WORD_LAST) begin
                    word_cnt <= '0;
                    item_cnt <= item_cnt + 10'd1;
                end else begin
                    word_cnt <= word_cnt + WW'(1);
                end
            end

            // Shared cycle counter: restarts on every state change, used by drain and timeout.
            if (state_next != state) begin
                cnt <= '0;
            end else if ((state == S_GEN_DRAIN) || (state == S_WAIT_LAST)) begin
                cnt <= cnt + CW'(1);
            end

            if (start_ok || issue_fire) begin
                slot_cnt  <= '0;
                last_seen <= 1'b0;
                for (int k = 0; k < THREADS; k++) begin
                    slots[k] <= '0;
                end
            end else if (fetch_accept) begin
                slots[slot_cnt] <= s_data[15:0];
                slot_cnt        <= slot_cnt + SW'(1);
                last_seen       <= s_last;
            end
        end
    end

endmodule

// File: tb/tb_hpu_sequencer.sv
// tb/tb_hpu_sequencer.sv - directed self-checking bench for hpu_sequencer
module tb_hpu_sequencer;

    localparam int THREADS = 5;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic                  gen_en = 1'b0;
    logic [9:0]            item_count = '0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [31:0]           s_data = '0;
    logic                  s_last = 1'b0;
    logic                  out_ready = 1'b1;
    logic                  core_last = 1'b0;
    logic                  run;
    logic                  com;
    logic                  get_c;
    logic [31:0]           get_d_all;
    logic                  get_v;
    logic [16*THREADS-1:0] get_d;
    logic                  exec;
    logic                  busy;
    logic                  done;
    logic                  err;

    hpu_sequencer #(.THREADS(THREADS), .WI(31), .LAST_TO(8)) dut (
        .clk(clk), .reset(reset), .start(start), .gen_en(gen_en),
        .item_count(item_count), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .out_ready(out_ready),
        .core_last(core_last), .run(run), .com(com), .get_c(get_c),
        .get_d_all(get_d_all), .get_v(get_v), .get_d(get_d), .exec(exec),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] gen_q [$];
    logic [79:0] bun_q [$];
    int          exec_bad = 0;
    int          b2b = 0;
    int          dz_bad = 0;
    int          done_cnt = 0;
    logic        gv_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (get_c) gen_q.push_back(get_d_all);
            if (get_v) begin
                bun_q.push_back(get_d);
                if (gv_prev) b2b <= b2b + 1;
            end
            if (!get_v && (get_d != '0)) dz_bad <= dz_bad + 1;
            if (exec !== gv_prev) exec_bad <= exec_bad + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
        gv_prev <= reset ? 1'b0 : get_v;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        core_last = 1'b0; out_ready = 1'b1;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic ge, input logic [9:0] n);
        gen_en = ge; item_count = n; start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!s_ready && n < 200) begin
            tick;
            n++;
        end
        check_eq("send_ready", s_ready, 1'b1);
        tick;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_bundles(input int n);
        int k;
        k = 0;
        while (bun_q.size() < n && k < 100) begin
            tick;
            k++;
        end
        check_eq("bundle_wait", bun_q.size() >= n, 1'b1);
    endtask

    task automatic finish_job(input string tag);
        int d0;
        d0 = done_cnt;
        core_last = 1'b1;
        tick;
        core_last = 1'b0;
        check_eq({tag, "_done"}, done, 1'b1);
        check_eq({tag, "_run_in_done"}, run, 1'b1);
        tick;
        check_eq({tag, "_run_off"}, {run, busy, done}, 3'b000);
        check_eq({tag, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    int n;
    int gq0;
    int bq0;

    initial begin
        // Reset state
        do_reset;
        check_eq("reset_ctrl", {s_ready, run, com, get_c, get_v, exec, busy, done, err}, 9'd0);
        check_eq("reset_get_d_all", get_d_all, 32'd0);
        check_eq("reset_get_d", get_d, 80'd0);

        // GEN: two items, 64 words
        gq0 = gen_q.size();
        pulse_start(1'b1, 10'd2);
        check_eq("gen_enter", {run, com, busy, s_ready, err}, 5'b11110);
        for (int i = 0; i < 64; i++) send(32'(i), 1'b1);
        check_eq("gen_drain_ctrl", {com, s_ready, get_c}, 3'b101);
        check_eq("gen_last_word", get_d_all, 32'd63);
        n = 0;
        while (com && n < 10) begin
            tick;
            n++;
        end
        check_eq("gen_com_drain_cycles", n, 3);
        check_eq("gen_fetch_ready", {s_ready, run, get_c}, 3'b110);
        check_eq("gen_word_count", gen_q.size() - gq0, 64);
        for (int i = 0; i < 64; i++) check_eq("gen_word", gen_q[gq0 + i], 32'(i));
        do_reset;

        // EXEC: 10 instructions, two full bundles
        bq0 = bun_q.size();
        pulse_start(1'b0, 10'd0);
        check_eq("exec_enter", {run, com, s_ready}, 3'b101);
        for (int i = 0; i < 9; i++) send({16'hABCD, 16'h1000 + 16'(i)}, 1'b0);
        send({16'hABCD, 16'h0100}, 1'b1);
        wait_bundles(bq0 + 2);
        check_eq("exec_b0", bun_q[bq0], {16'h1004, 16'h1003, 16'h1002, 16'h1001, 16'h1000});
        check_eq("exec_b1", bun_q[bq0 + 1], {16'h0100, 16'h1008, 16'h1007, 16'h1006, 16'h1005});
        finish_job("exec");

        // Partial bundle: 7 instructions
        bq0 = bun_q.size();
        pulse_start(1'b0, 10'd0);
        for (int i = 0; i < 6; i++) send({16'h0, 16'h2000 + 16'(i)}, 1'b0);
        send({16'h0, 16'h0100}, 1'b1);
        wait_bundles(bq0 + 2);
        check_eq("part_b0", bun_q[bq0], {16'h2004, 16'h2003, 16'h2002, 16'h2001, 16'h2000});
        check_eq("part_b1", bun_q[bq0 + 1], {16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h2005});
        finish_job("part");

        // Backpressure: out_ready low for 4 ISSUE cycles
        pulse_start(1'b0, 10'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send({16'h0, 16'h3000 + 16'(i)}, 1'b0);
        send({16'h0, 16'h0100}, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_hold", {get_v, s_ready}, 2'b00);
            tick;
        end
        out_ready = 1'b1;
        tick;
        check_eq("bp_issue_v", get_v, 1'b1);
        check_eq("bp_issue_d", get_d, {16'h0100, 16'h3003, 16'h3002, 16'h3001, 16'h3000});
        tick;
        check_eq("bp_single_cycle", {get_v, exec, get_d == 80'd0}, 3'b011);
        finish_job("bp");

        // Timeout: core_last never arrives
        pulse_start(1'b0, 10'd0);
        for (int i = 0; i < 4; i++) send({16'h0, 16'h4000 + 16'(i)}, 1'b0);
        send({16'h0, 16'h4004}, 1'b1);
        n = 0;
        while (!get_v && n < 20) begin
            tick;
            n++;
        end
        check_eq("to_issue_seen", get_v, 1'b1);
        n = 0;
        while (!done && n < 30) begin
            tick;
            n++;
        end
        check_eq("to_cycles", n, 8);
        check_eq("to_err_done", {err, done}, 2'b11);
        tick; tick;
        check_eq("to_err_sticky", {err, busy}, 2'b10);
        pulse_start(1'b0, 10'd0);
        check_eq("to_err_cleared", {err, run}, 2'b01);
        do_reset;

        // item_count above 512 flags err and ends at once
        pulse_start(1'b1, 10'd600);
        check_eq("big_count", {done, err, run, com}, 4'b1110);
        tick;
        check_eq("big_count_after", {done, err, run, busy}, 4'b0100);

        // item_count 0 with gen_en skips GEN
        pulse_start(1'b1, 10'd0);
        check_eq("zero_items", {com, s_ready, run, err}, 4'b0110);
        send({16'h0, 16'h0100}, 1'b1);
        wait_bundles(bun_q.size() + 1);
        finish_job("zero");

        // Reset mid-GEN, then a fresh one-item load
        pulse_start(1'b1, 10'd1);
        for (int i = 0; i < 10; i++) send(32'd100 + 32'(i), 1'b0);
        reset = 1'b1;
        tick;
        check_eq("midreset", {com, run, busy, s_ready}, 4'b0000);
        reset = 1'b0;
        gq0 = gen_q.size();
        pulse_start(1'b1, 10'd1);
        for (int i = 0; i < 32; i++) send(32'd200 + 32'(i), 1'b0);
        n = 0;
        while (com && n < 10) begin
            tick;
            n++;
        end
        check_eq("restart_drain", n, 3);
        check_eq("restart_count", gen_q.size() - gq0, 32);
        check_eq("restart_first", gen_q[gq0], 32'd200);
        check_eq("restart_last", gen_q[gq0 + 31], 32'd231);
        do_reset;

        check_eq("exec_follows_get_v", exec_bad, 0);
        check_eq("no_back_to_back", b2b, 0);
        check_eq("get_d_zero_idle", dz_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
